// File: rtl/counter_pkg.sv
// Shared definitions for the mod-N prescaled counter slice.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // clog2 of the prescale ratio, held at one bit so PRESCALE=1 still has a legal phase register.
  function automatic int unsigned phase_width(input int unsigned prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enable-tick generator: counts enabled cycles 0..PRESCALE-1 and pulses tick on the last one.
// Only instantiated when PRESCALER_EN is defined.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned PW = phase_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  assign tick = enable && (phase_q == LAST);

  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = '0;
    end else if (tick) begin
      phase_d = '0;
    end else if (enable) begin
      phase_d = phase_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/modn_prescaled_counter.sv
// Up/down modulo-MOD_N counter with saturating parallel load and a registered wrap pulse.
// Define PRESCALER_EN to step only once every PRESCALE enabled cycles.
module modn_prescaled_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MOD_N    = 10,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  if (MOD_N < 2 || MOD_N > (2 ** WIDTH) || PRESCALE < 1) begin : g_param_check
    $fatal(1, "modn_prescaled_counter: illegal WIDTH/MOD_N/PRESCALE combination");
  end

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MOD_N - 1);

  logic             step_tick;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;

`ifdef PRESCALER_EN
  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .clear (load),
    .tick  (step_tick)
  );
`else
  assign step_tick = 1'b1;
`endif

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = (load_value > CNT_MAX) ? CNT_MAX : load_value;
    end else if (enable && step_tick) begin
      if (up_down == DIR_UP) begin
        if (count_q == CNT_MAX) begin
          count_d = '0;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = CNT_MAX;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

endmodule
